snd_reg_arbiter: RTL and testbench



---
 rtl/snd_pkg.sv | 35 +++
 rtl/snd_shadow_ram.sv | 28 ++
 rtl/snd_reg_arbiter.sv | 118 +++++++++++
 tb/tb_snd_reg_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared types and constants for the WSG sound-register arbiter.
// The SND_SHADOW_RD_EN build option is handled in snd_reg_arbiter.
package snd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } snd_state_e;

    localparam logic [9:0] SND_WIN_BASE = 10'h000;
    localparam int         SND_ADR_W    = 6;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Request as seen on the granted port in IDLE.
    typedef struct packed {
        logic                 port;
        logic                 we;
        logic [SND_ADR_W-1:0] adr;
        logic [7:0]           wdat;
    } snd_req_t;

    // Only port and direction need to live past the grant edge.
    typedef struct packed {
        logic port;
        logic we;
    } snd_gnt_t;

    function automatic logic [15:0] snd_sa(input logic [SND_ADR_W-1:0] adr);
        return {SND_WIN_BASE, adr};
    endfunction

endpackage

// File: rtl/snd_shadow_ram.sv
// 64x8 shadow of the WSG register window: synchronous write,
// registered read, asynchronous clear to the WSG reset state.
module snd_shadow_ram
    import snd_pkg::*;
(
    input  logic                 pxclk,
    input  logic                 RESET_N,
    input  logic                 we,
    input  logic [SND_ADR_W-1:0] wadr,
    input  logic [7:0]           wdat,
    input  logic                 re,
    input  logic [SND_ADR_W-1:0] radr,
    output logic [7:0]           rdat
);

    logic [(1<<SND_ADR_W)-1:0][7:0] mem;

    always_ff @(posedge pxclk or negedge RESET_N) begin
        if (!RESET_N) begin
            mem  <= '0;
            rdat <= '0;
        end else begin
            if (we) mem[wadr] <= wdat;
            if (re) rdat <= mem[radr];
        end
    end

endmodule

// File: rtl/snd_reg_arbiter.sv
// Round-robin arbiter sharing the WSG register window between two CPUs.
// Build option SND_SHADOW_RD_EN: build the shadow RAM so reads return register state.
module snd_reg_arbiter
    import snd_pkg::*;
#(
    parameter logic [15:0] IDLE_SA = 16'hFFFF,
    parameter logic        RR_INIT = 1'b0
) (
    input  logic                 pxclk,
    input  logic                 RESET_N,
    input  logic                 A_REQ,
    input  logic                 A_WE,
    input  logic [SND_ADR_W-1:0] A_ADR,
    input  logic [7:0]           A_WDAT,
    output logic                 A_ACK,
    output logic [7:0]           A_RDAT,
    input  logic                 B_REQ,
    input  logic                 B_WE,
    input  logic [SND_ADR_W-1:0] B_ADR,
    input  logic [7:0]           B_WDAT,
    output logic                 B_ACK,
    output logic [7:0]           B_RDAT,
    output logic [15:0]          SA,
    output logic [7:0]           SDATA,
    output logic                 BUSY
);

    snd_state_e state, state_nxt;
    logic       rr_ptr;
    logic       grant;
    logic       gnt_port;
    snd_req_t   sel;
    snd_gnt_t   cur;
    logic [7:0] rd_val;

    always_ff @(posedge pxclk or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_port  = rr_ptr;
        case (state)
            IDLE: begin
                if (A_REQ || B_REQ) begin
                    grant     = 1'b1;
                    state_nxt = ACC;
                    if (A_REQ && !B_REQ)      gnt_port = PORT_A;
                    else if (B_REQ && !A_REQ) gnt_port = PORT_B;
                end
            end
            ACC:     state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (gnt_port == PORT_A) sel = '{port: PORT_A, we: A_WE, adr: A_ADR, wdat: A_WDAT};
        else                    sel = '{port: PORT_B, we: B_WE, adr: B_ADR, wdat: B_WDAT};
    end

`ifdef SND_SHADOW_RD_EN
    // SA/SDATA hold the write during ACC, so the shadow updates on the
    // same edge the WSG samples it and the two can never diverge.
    snd_shadow_ram u_shadow (
        .pxclk   (pxclk),
        .RESET_N (RESET_N),
        .we      ((state == ACC) && cur.we),
        .wadr    (SA[SND_ADR_W-1:0]),
        .wdat    (SDATA),
        .re      (grant && !sel.we),
        .radr    (sel.adr),
        .rdat    (rd_val)
    );
`else
    assign rd_val = 8'hFF;
`endif

    always_ff @(posedge pxclk or negedge RESET_N) begin
        if (!RESET_N) begin
            cur    <= '0;
            rr_ptr <= RR_INIT;
            SA     <= IDLE_SA;
            SDATA  <= '0;
            A_ACK  <= 1'b0;
            B_ACK  <= 1'b0;
            A_RDAT <= '0;
            B_RDAT <= '0;
            BUSY   <= 1'b0;
        end else begin
            A_ACK <= 1'b0;
            B_ACK <= 1'b0;
            SA    <= IDLE_SA;
            SDATA <= '0;
            BUSY  <= (state_nxt != IDLE);
            if (grant) begin
                cur <= '{port: sel.port, we: sel.we};
                if (sel.we) begin
                    SA    <= snd_sa(sel.adr);
                    SDATA <= sel.wdat;
                end
            end
            if (state == ACC) begin
                if (cur.port == PORT_A) A_ACK <= 1'b1;
                else                    B_ACK <= 1'b1;
                if (!cur.we) begin
                    if (cur.port == PORT_A) A_RDAT <= rd_val;
                    else                    B_RDAT <= rd_val;
                end
            end
            if (state == ACK) rr_ptr <= ~cur.port;
        end
    end

endmodule

// File: tb/tb_snd_reg_arbiter.sv
// Self-checking bench for snd_reg_arbiter against a transaction-level model.
module tb_snd_reg_arbiter;

    logic        pxclk = 1'b0;
    logic        RESET_N = 1'b0;
    logic        A_REQ = 1'b0, A_WE = 1'b0;
    logic [5:0]  A_ADR = '0;
    logic [7:0]  A_WDAT = '0;
    logic        B_REQ = 1'b0, B_WE = 1'b0;
    logic [5:0]  B_ADR = '0;
    logic [7:0]  B_WDAT = '0;
    logic        A_ACK, B_ACK, BUSY;
    logic [7:0]  A_RDAT, B_RDAT, SDATA;
    logic [15:0] SA;

    snd_reg_arbiter #(.IDLE_SA(16'hFFFF), .RR_INIT(1'b0)) dut (
        .pxclk(pxclk), .RESET_N(RESET_N),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADR(A_ADR), .A_WDAT(A_WDAT), .A_ACK(A_ACK), .A_RDAT(A_RDAT),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADR(B_ADR), .B_WDAT(B_WDAT), .B_ACK(B_ACK), .B_RDAT(B_RDAT),
        .SA(SA), .SDATA(SDATA), .BUSY(BUSY)
    );

    always #5 pxclk = ~pxclk;

    typedef struct {bit we; bit [5:0] adr; bit [7:0] wd;} op_t;
    op_t qa[$], qb[$];
    op_t ag_op[2];
    int  ag_st[2];            // 0 idle, 1 requesting, 2 one-cycle drop after ack
    bit  rnd_en, hold_all;

    int errors = 0, checks = 0;

    // model: register file, who is favoured next, and the one access in flight
    bit [7:0] shadow[64];
    bit [7:0] m_rdat[2];
    int  favored, free_at, g_edge, g_port, cyc;
    bit  g_we;
    bit [5:0] g_adr;
    bit [7:0] g_wd, g_rval;

    int pulses, last_pulse, last_ack_port, n_acks;
    int last_ack[2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_SA"}, SA, 16'hFFFF);
        chk({tag, "_SDATA"}, SDATA, 16'h0);
        chk({tag, "_A_ACK"}, A_ACK, 16'h0);
        chk({tag, "_B_ACK"}, B_ACK, 16'h0);
        chk({tag, "_BUSY"}, BUSY, 16'h0);
        chk({tag, "_A_RDAT"}, A_RDAT, 16'h0);
        chk({tag, "_B_RDAT"}, B_RDAT, 16'h0);
    endtask

    task automatic model_reset();
        foreach (shadow[i]) shadow[i] = 8'h00;
        m_rdat[0] = 8'h00; m_rdat[1] = 8'h00;
        favored = 0; free_at = 0; g_edge = -100;
        ag_st[0] = 0; ag_st[1] = 0;
        qa.delete(); qb.delete();
        A_REQ = 1'b0; B_REQ = 1'b0;
    endtask

    task automatic step();
        bit ack_now;
        logic [15:0] exp_sa;
        logic [7:0]  exp_sd;
        for (int p = 0; p < 2; p++) begin
            if (hold_all) begin
                ag_op[p] = '{1'b0, 6'h04, 8'h00};
                ag_st[p] = 1;
            end else if (ag_st[p] == 2) begin
                ag_st[p] = 0;
            end else if (ag_st[p] == 0) begin
                if (p == 0 && qa.size() > 0) begin
                    ag_op[0] = qa.pop_front(); ag_st[0] = 1;
                end else if (p == 1 && qb.size() > 0) begin
                    ag_op[1] = qb.pop_front(); ag_st[1] = 1;
                end else if (rnd_en && $urandom_range(0, 2) == 0) begin
                    ag_op[p].we  = 1'($urandom_range(0, 1));
                    ag_op[p].adr = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
                    ag_op[p].wd  = 8'($urandom);
                    ag_st[p] = 1;
                end
            end
        end
        A_REQ = (ag_st[0] == 1); A_WE = ag_op[0].we; A_ADR = ag_op[0].adr; A_WDAT = ag_op[0].wd;
        B_REQ = (ag_st[1] == 1); B_WE = ag_op[1].we; B_ADR = ag_op[1].adr; B_WDAT = ag_op[1].wd;

        @(posedge pxclk);
        if (cyc >= free_at && (ag_st[0] == 1 || ag_st[1] == 1)) begin
            if (ag_st[0] == 1 && ag_st[1] == 1) g_port = favored;
            else                                g_port = (ag_st[0] == 1) ? 0 : 1;
            favored = 1 - g_port;
            g_edge  = cyc;
            free_at = cyc + 3;
            g_we  = ag_op[g_port].we;
            g_adr = ag_op[g_port].adr;
            g_wd  = ag_op[g_port].wd;
            if (g_we) shadow[g_adr] = g_wd;
`ifdef SND_SHADOW_RD_EN
            g_rval = shadow[g_adr];
`else
            g_rval = 8'hFF;
`endif
        end

        @(negedge pxclk);
        exp_sa  = (cyc == g_edge && g_we) ? {10'h000, g_adr} : 16'hFFFF;
        exp_sd  = (cyc == g_edge && g_we) ? g_wd : 8'h00;
        ack_now = (cyc == g_edge + 1);
        if (ack_now && !g_we) m_rdat[g_port] = g_rval;
        chk("SA", SA, exp_sa);
        chk("SDATA", SDATA, exp_sd);
        chk("A_ACK", A_ACK, (ack_now && g_port == 0));
        chk("B_ACK", B_ACK, (ack_now && g_port == 1));
        chk("BUSY", BUSY, (cyc == g_edge || ack_now));
        chk("A_RDAT", A_RDAT, m_rdat[0]);
        chk("B_RDAT", B_RDAT, m_rdat[1]);

        if (SA !== 16'hFFFF) begin
            pulses++;
            if (last_pulse >= 0) chk("SA_GAP_OK", (cyc - last_pulse >= 3), 1);
            last_pulse = cyc;
        end
        if (hold_all && (A_ACK === 1'b1 || B_ACK === 1'b1)) begin
            int p;
            p = (A_ACK === 1'b1) ? 0 : 1;
            n_acks++;
            if (last_ack_port >= 0) chk("RR_ALTERNATE", p, 1 - last_ack_port);
            if (last_ack[p] >= 0)   chk("RR_SPACING", cyc - last_ack[p], 6);
            last_ack_port = p;
            last_ack[p]   = cyc;
        end
        if (ack_now && !hold_all) ag_st[g_port] = 2;
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ag_st[0] != 0 || ag_st[1] != 0 || qa.size() > 0 || qb.size() > 0 || cyc < free_at) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) chk("DRAIN_TIMEOUT", 0, 1);
    endtask

    initial begin
        cyc = 0; rnd_en = 0; hold_all = 0;
        pulses = 0; last_pulse = -1;
        model_reset();

        // reset state
        repeat (2) @(posedge pxclk);
        @(negedge pxclk);
        chk_idle_outputs("RESET");
        RESET_N = 1'b1;

        // contention, same address; A favoured first after reset
        qa.push_back('{1'b1, 6'h04, 8'h11});
        qb.push_back('{1'b1, 6'h04, 8'h22});
        qb.push_back('{1'b0, 6'h04, 8'h00});
        drain();

        // single write and read-back
        qa.push_back('{1'b1, 6'h0B, 8'h05});
        qa.push_back('{1'b0, 6'h0B, 8'h00});
        drain();

        // port B write then read
        qb.push_back('{1'b1, 6'h10, 8'h7A});
        qb.push_back('{1'b0, 6'h10, 8'h00});
        drain();

        // fairness with both requests held
        last_ack_port = -1; last_ack[0] = -1; last_ack[1] = -1; n_acks = 0;
        hold_all = 1;
        repeat (14) step();
        hold_all = 0;
        chk("RR_ACK_COUNT_OK", (n_acks >= 4), 1);
        drain();

        // back-to-back writes over the whole window, then read back
        pulses = 0; last_pulse = -1;
        for (int i = 0; i < 64; i++) qa.push_back('{1'b1, 6'(i), 8'((i * 37 + 5) & 8'hFF)});
        drain();
        chk("B2B_PULSES", pulses, 64);
        for (int i = 0; i < 64; i++) qa.push_back('{1'b0, 6'(i), 8'h00});
        drain();

        // random traffic on both ports
        rnd_en = 1;
        repeat (400) step();
        rnd_en = 0;
        drain();

        // reset in the middle of a write
        qa.push_back('{1'b1, 6'h0B, 8'hAA});
        step();
        #1 RESET_N = 1'b0;
        #1 chk_idle_outputs("MIDRST");
        model_reset();
        repeat (2) @(posedge pxclk);
        @(negedge pxclk);
        chk_idle_outputs("MIDRST_HOLD");
        RESET_N = 1'b1;
        qa.push_back('{1'b0, 6'h0B, 8'h00});
        qb.push_back('{1'b0, 6'h04, 8'h00});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
